// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable serial sequence detector.
//   OVERLAP / NON_OVERLAP : values of the cfg_overlap mode bit
//   clamp_len()           : maps a requested pattern length onto 1..max_len;
//                           0 or anything above max_len selects max_len
// ----------------------------------------------------------------------------
package seq_det_pkg;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0 || len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating event counter with a sticky overflow flag.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   inc   : count one event
//   clr   : synchronous clear of cnt and sat (dominates inc)
//   cnt   : current count, holds at 2^W-1
//   sat   : set when an event arrives while cnt is already at its maximum
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) sat <= 1'b1;
      else                cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// ----------------------------------------------------------------------------
// seq_detector_prog
// Programmable serial pattern detector with match counting.
//   CLK         : clock, rising edge
//   RST_N       : asynchronous active-low reset
//   x_valid, x  : qualified serial input bit
//   cfg_load    : strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern : pattern; first-received bit sits at [len-1], last at [0]
//   cfg_len     : active length (0 or >PAT_W means PAT_W)
//   cfg_overlap : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr     : synchronous clear of match_cnt and cnt_sat
//   y           : one-cycle registered match pulse
//   fill        : valid history bits held, 0..len
//   match_cnt   : saturating match count
//   cnt_sat     : sticky counter-saturated flag
// ----------------------------------------------------------------------------
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int               PAT_W   = 4,
  parameter  logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b0101),
  parameter  int               CNT_W   = 8,
  localparam int               LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             x_valid,
  input  logic             x,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [LEN_W-1:0] fill,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             overlap_reg;
  logic [PAT_W-1:0] hist_reg;
  logic [LEN_W-1:0] fill_reg;
  logic             y_reg;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic             accept;
  logic             match;

  // Only the newest len history bits take part in the comparison.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  always_comb begin
    // A configuration load in the same cycle swallows the incoming bit.
    accept    = x_valid && !cfg_load;
    hist_next = {hist_reg[PAT_W-2:0], x};
    fill_next = (fill_reg < len_reg) ? fill_reg + 1'b1 : fill_reg;
    match     = accept && (fill_next == len_reg) &&
                (((hist_next ^ pat_reg) & mask) == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pat_reg     <= DEF_PAT;
      len_reg     <= LEN_W'(PAT_W);
      overlap_reg <= OVERLAP;
      hist_reg    <= '0;
      fill_reg    <= '0;
      y_reg       <= 1'b0;
    end else begin
      y_reg <= match;
      if (cfg_load) begin
        pat_reg     <= cfg_pattern;
        len_reg     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
        overlap_reg <= cfg_overlap;
        hist_reg    <= '0;
        fill_reg    <= '0;
      end else if (accept) begin
        hist_reg <= hist_next;
        // Non-overlapping mode restarts the window after a hit; overlapping
        // mode keeps fill at len so the very next bit can complete a match.
        fill_reg <= (match && overlap_reg == NON_OVERLAP) ? '0 : fill_next;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (match),
    .clr   (cnt_clr),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign y    = y_reg;
  assign fill = fill_reg;

endmodule

// File: tb/tb_seq_detector_prog.sv
// ----------------------------------------------------------------------------
// tb_seq_detector_prog
// Directed stimulus against seq_detector_prog (PAT_W=4, CNT_W=2) with a
// queue-based reference model compared every cycle, plus literal checks.
// ----------------------------------------------------------------------------
module tb_seq_detector_prog;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'd0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       y;
  logic [2:0] fill;
  logic [1:0] match_cnt;
  logic       cnt_sat;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_detector_prog #(
    .PAT_W   (4),
    .DEF_PAT (4'b0101),
    .CNT_W   (2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .x_valid     (x_valid),
    .x           (x),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .y           (y),
    .fill        (fill),
    .match_cnt   (match_cnt),
    .cnt_sat     (cnt_sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted bits since the last reset/load/non-overlap hit, newest at back.
  int         q[$];
  logic [3:0] m_pat = 4'b0101;
  int         m_len = 4;
  bit         m_ovl = 1'b1;
  int         m_cnt = 0;
  bit         m_sat = 1'b0;
  bit         m_y = 1'b0;
  bit         m_match;
  int         m_fill;

  always @(negedge RST_N) begin
    q.delete();
    m_pat = 4'b0101; m_len = 4; m_ovl = 1'b1;
    m_cnt = 0; m_sat = 1'b0; m_y = 1'b0;
  end

  always @(posedge CLK) begin
    if (RST_N) begin
      m_match = 1'b0;
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len == 0 || cfg_len > 4) ? 4 : int'(cfg_len);
        m_ovl = cfg_overlap;
        q.delete();
      end else if (x_valid) begin
        q.push_back(int'(x));
        if (q.size() > 4) void'(q.pop_front());
        if (q.size() >= m_len) begin
          m_match = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (q[q.size() - 1 - k] != int'(m_pat[k])) m_match = 1'b0;
        end
        if (m_match && !m_ovl) q.delete();
      end
      m_y = m_match;
      if (cnt_clr) begin
        m_cnt = 0; m_sat = 1'b0;
      end else if (m_match) begin
        if (m_cnt == 3) m_sat = 1'b1;
        else m_cnt++;
      end
    end
    #1;
    m_fill = (q.size() < m_len) ? q.size() : m_len;
    check("model_y", 32'(y), 32'(m_y));
    check("model_fill", 32'(fill), 32'(m_fill));
    check("model_cnt", 32'(match_cnt), 32'(m_cnt));
    check("model_sat", 32'(cnt_sat), 32'(m_sat));
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic bit_in(input logic v, input logic b, input logic clr);
    x_valid = v; x = b; cnt_clr = clr; cfg_load = 1'b0;
    @(negedge CLK);
    x_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n,
                        input logic [15:0] exp_y, input string tag);
    for (int i = 0; i < n; i++) begin
      bit_in(1'b1, bits[n-1-i], 1'b0);
      check($sformatf("%s_y_bit%0d", tag, i + 1), 32'(y), 32'(exp_y[n-1-i]));
    end
  endtask

  task automatic load(input logic [3:0] pat, input logic [2:0] len, input logic ovl,
                      input logic xv, input logic xb, input string tag);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    x_valid = xv; x = xb;
    @(negedge CLK);
    cfg_load = 1'b0; x_valid = 1'b0;
    check({tag, "_load_y"}, 32'(y), 32'd0);
    check({tag, "_load_fill"}, 32'(fill), 32'd0);
  endtask

  logic [1:0] e_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
  logic       e_sat[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_y", 32'(y), 32'd0);
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_cnt", 32'(match_cnt), 32'd0);
    check("reset_sat", 32'(cnt_sat), 32'd0);
    RST_N = 1'b1;
    $display("reset released, checks=%0d", checks);

    // Defaults, overlapping: hits after bits 4 and 6.
    stream(16'b010101, 6, 16'b000101, "A");
    check("A_cnt", 32'(match_cnt), 32'd2);
    bit_in(1'b0, 1'b0, 1'b1);
    check("A_clr_cnt", 32'(match_cnt), 32'd0);
    $display("case A done, checks=%0d failures=%0d", checks, failures);

    // Non-overlapping: only the first hit.
    load(4'b0101, 3'd4, 1'b0, 1'b0, 1'b0, "B");
    stream(16'b010101, 6, 16'b000100, "B");
    check("B_cnt", 32'(match_cnt), 32'd1);
    $display("case B done, checks=%0d failures=%0d", checks, failures);

    // len=0 selects full width; idle gap holds fill.
    load(4'b0101, 3'd0, 1'b1, 1'b0, 1'b0, "C");
    stream(16'b01, 2, 16'b00, "C1");
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b0, 1'b1, 1'b0);
      check("C_gap_fill", 32'(fill), 32'd2);
      check("C_gap_y", 32'(y), 32'd0);
    end
    stream(16'b01, 2, 16'b01, "C2");
    check("C_cnt", 32'(match_cnt), 32'd2);
    $display("case C done, checks=%0d failures=%0d", checks, failures);

    // Reload mid-stream, load coincident with a valid bit (bit dropped).
    load(4'b0101, 3'd4, 1'b1, 1'b0, 1'b0, "D0");
    stream(16'b11, 2, 16'b00, "D0");
    load(4'b0110, 3'd3, 1'b1, 1'b1, 1'b0, "D");
    stream(16'b110, 3, 16'b001, "D");
    check("D_fill", 32'(fill), 32'd3);
    check("D_cnt", 32'(match_cnt), 32'd3);
    $display("case D done, checks=%0d failures=%0d", checks, failures);

    // Saturation with CNT_W=2; clear coincident with the 5th hit.
    bit_in(1'b0, 1'b0, 1'b1);
    check("E_clr_cnt", 32'(match_cnt), 32'd0);
    load(4'b0101, 3'd4, 1'b1, 1'b0, 1'b0, "E");
    stream(16'b010, 3, 16'b000, "E0");
    for (int m = 0; m < 5; m++) begin
      bit_in(1'b1, 1'b1, (m == 4) ? 1'b1 : 1'b0);
      check($sformatf("E_y_hit%0d", m + 1), 32'(y), 32'd1);
      check($sformatf("E_cnt_hit%0d", m + 1), 32'(match_cnt), 32'(e_cnt[m]));
      check($sformatf("E_sat_hit%0d", m + 1), 32'(cnt_sat), 32'(e_sat[m]));
      if (m < 4) begin
        bit_in(1'b1, 1'b0, 1'b0);
        check("E_y_gap", 32'(y), 32'd0);
      end
    end
    $display("case E done, checks=%0d failures=%0d", checks, failures);

    // Asynchronous reset between bits 3 and 4.
    load(4'b0101, 3'd4, 1'b1, 1'b0, 1'b0, "F");
    stream(16'b010, 3, 16'b000, "F0");
    RST_N = 1'b0;
    #1;
    check("F_rst_fill", 32'(fill), 32'd0);
    check("F_rst_y", 32'(y), 32'd0);
    check("F_rst_cnt", 32'(match_cnt), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    bit_in(1'b1, 1'b1, 1'b0);
    check("F_bit4_y", 32'(y), 32'd0);
    stream(16'b0101, 4, 16'b0001, "F");
    check("F_cnt", 32'(match_cnt), 32'd1);
    $display("case F done, checks=%0d failures=%0d", checks, failures);

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
